riscv_cmd_prefetch_queue: RTL and testbench

- Downstream neighbour of riscv_command_streamer.
- Accepts the streamer's stream of 32-bit RISC-V instruction words, each with its PC, over a valid/ready handshake.
- Buffers them in a small FIFO and presents them first-word-fall-through to the decode stage.
- Supports a one-cycle flush on redirect, flags non-32-bit encodings, and keeps occupancy and dispatch counters for debug.

---
 rtl/riscv_cmd_prefetch_queue.sv | 112 +++++++++++
 tb/tb_riscv_cmd_prefetch_queue.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_cmd_prefetch_queue.sv
// Prefetch FIFO between the command streamer and decode: first-word-fall-through,
// flush on redirect, compressed-encoding flag and debug counters.
module riscv_cmd_prefetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [XLEN-1:0]          in_instr,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output logic [XLEN-1:0]          out_instr,
    output logic                     out_illegal,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         dispatched
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] FullCount = CntW'(DEPTH);

    logic [XLEN-1:0] pc_mem_q    [DEPTH];
    logic [XLEN-1:0] pc_mem_d    [DEPTH];
    logic [XLEN-1:0] instr_mem_q [DEPTH];
    logic [XLEN-1:0] instr_mem_d [DEPTH];

    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [CNT_W-1:0] dispatched_q, dispatched_d;

    logic push, pop;

    // Ready depends only on state, reset and flush, never on out_ready.
    always_comb begin
        in_ready  = !reset && !flush && (count_q != FullCount);
        out_valid = (count_q != '0);
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready && !flush;
    end

    always_comb begin
        out_pc      = '0;
        out_instr   = '0;
        out_illegal = 1'b0;
        if (out_valid) begin
            out_pc      = pc_mem_q[rd_ptr_q];
            out_instr   = instr_mem_q[rd_ptr_q];
            out_illegal = (instr_mem_q[rd_ptr_q][1:0] != 2'b11);
        end
        count      = count_q;
        dispatched = dispatched_q;
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        dispatched_d = dispatched_q;
        pc_mem_d     = pc_mem_q;
        instr_mem_d  = instr_mem_q;

        if (push) begin
            pc_mem_d[wr_ptr_q]    = in_pc;
            instr_mem_d[wr_ptr_q] = in_instr;
        end

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop) begin
                rd_ptr_d     = rd_ptr_q + PtrW'(1);
                dispatched_d = dispatched_q + CNT_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            dispatched_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            dispatched_q <= dispatched_d;
        end
    end

    // Payload storage is deliberately left untouched by reset and flush.
    always_ff @(posedge clk) begin
        pc_mem_q    <= pc_mem_d;
        instr_mem_q <= instr_mem_d;
    end

endmodule

// File: tb/tb_riscv_cmd_prefetch_queue.sv
// Self-checking bench: queue-based reference model, an encoding table and
// hand-written corner sequences, followed by randomized traffic.
module tb_riscv_cmd_prefetch_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             reset, in_valid, in_ready, flush;
    logic             out_valid, out_ready, out_illegal;
    logic [XLEN-1:0]  in_pc, in_instr, out_pc, out_instr;
    logic [2:0]       count;
    logic [CNT_W-1:0] dispatched;

    riscv_cmd_prefetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pc       (in_pc),
        .in_instr    (in_instr),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_instr   (out_instr),
        .out_illegal (out_illegal),
        .count       (count),
        .dispatched  (dispatched)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_pc[$];
    logic [31:0] m_instr[$];
    logic [31:0] m_disp;

    typedef struct {
        logic [31:0] instr;
        logic        exp_illegal;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic        ev;
        logic [31:0] hi;
        ev = (m_pc.size() != 0);
        hi = ev ? m_instr[0] : 32'h0;
        chk("out_valid", 64'(out_valid), 64'(ev));
        chk("count", 64'(count), 64'(m_pc.size()));
        chk("in_ready", 64'(in_ready), 64'(!reset && !flush && (m_pc.size() < DEPTH)));
        chk("out_pc", 64'(out_pc), ev ? 64'(m_pc[0]) : 64'h0);
        chk("out_instr", 64'(out_instr), 64'(hi));
        chk("out_illegal", 64'(out_illegal), 64'(ev && (hi[1:0] != 2'b11)));
        chk("dispatched", 64'(dispatched), 64'(m_disp));
    endtask

    task automatic model_update();
        bit do_pop, do_push;
        do_pop  = !reset && !flush && out_ready && (m_pc.size() > 0);
        do_push = !reset && !flush && in_valid && (m_pc.size() < DEPTH);
        if (reset) begin
            m_pc.delete();
            m_instr.delete();
            m_disp = 0;
        end else if (flush) begin
            m_pc.delete();
            m_instr.delete();
        end else begin
            if (do_pop) begin
                void'(m_pc.pop_front());
                void'(m_instr.pop_front());
                m_disp = m_disp + 1;
            end
            if (do_push) begin
                m_pc.push_back(in_pc);
                m_instr.push_back(in_instr);
            end
        end
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic tick();
        #1;
        check_model();
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                         input logic rdy, input logic fl);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = rdy;
        flush     = fl;
    endtask

    initial begin
        vecs[0] = '{32'h0000_0013, 1'b0};
        vecs[1] = '{32'h0000_4501, 1'b1};
        vecs[2] = '{32'hFFFF_FFFF, 1'b0};
        vecs[3] = '{32'h0000_0002, 1'b1};
        vecs[4] = '{32'h0000_0001, 1'b1};
        vecs[5] = '{32'h0000_0033, 1'b0};

        reset = 1'b1;
        drive(1'b0, 0, 0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        m_pc.delete();
        m_instr.delete();
        m_disp = 0;
        tick();  // still in reset: in_ready must be low

        // First word after reset: one-cycle latency, no bypass
        reset = 1'b0;
        drive(1'b1, 32'h0, 32'h0000_0013, 1'b0, 1'b0);
        #1 chk("ready_after_reset", 64'(in_ready), 64'h1);
        chk("no_bypass", 64'(out_valid), 64'h0);
        tick();
        drive(1'b0, 0, 0, 1'b0, 1'b0);
        #1;
        chk("first_valid", 64'(out_valid), 64'h1);
        chk("first_instr", 64'(out_instr), 64'h13);
        chk("first_pc", 64'(out_pc), 64'h0);
        chk("first_illegal", 64'(out_illegal), 64'h0);
        chk("first_count", 64'(count), 64'h1);
        out_ready = 1'b1;
        tick();

        // Fill to full, fifth word held, then drain in order
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(i * 4), 32'h0000_0013 + 32'(i << 7), 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 32'h10, 32'h0000_0093, 1'b0, 1'b0);
        #1;
        chk("full_count", 64'(count), 64'h4);
        chk("full_in_ready", 64'(in_ready), 64'h0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 0, 0, 1'b1, 1'b0);
            #1 chk("drain_pc", 64'(out_pc), 64'(i * 4));
            tick();
        end
        #1 chk("drain_disp", 64'(dispatched), 64'h5);

        // Steady push/pop at count 2 for 20 cycles
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h100 + 32'(i * 4), 32'h0000_0013, 1'b0, 1'b0);
            tick();
        end
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 32'h108 + 32'(i * 4), 32'h0000_0013, 1'b1, 1'b0);
            #1;
            chk("stream_pc", 64'(out_pc), 64'(32'h100 + 32'(i * 4)));
            chk("stream_count", 64'(count), 64'h2);
            tick();
        end
        #1 chk("stream_disp", 64'(dispatched), 64'd25);
        drive(1'b0, 0, 0, 1'b1, 1'b0);
        tick();
        tick();

        // Flush with 3 queued, coincident push and pop attempt
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h200 + 32'(i * 4), 32'h0000_0013, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 32'h20C, 32'h0000_0013, 1'b1, 1'b1);
        #1 chk("flush_in_ready", 64'(in_ready), 64'h0);
        tick();
        drive(1'b1, 32'h300, 32'h0000_0033, 1'b0, 1'b0);
        #1;
        chk("flush_count", 64'(count), 64'h0);
        chk("flush_valid", 64'(out_valid), 64'h0);
        chk("flush_disp", 64'(dispatched), 64'd27);
        tick();
        drive(1'b0, 0, 0, 1'b0, 1'b0);
        #1 chk("post_flush_head", 64'(out_pc), 64'h300);
        out_ready = 1'b1;
        tick();

        // Encoding table
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'h400 + 32'(i * 4), vecs[i].instr, 1'b0, 1'b0);
            tick();
            drive(1'b0, 0, 0, 1'b1, 1'b0);
            #1;
            chk("tbl_instr", 64'(out_instr), 64'(vecs[i].instr));
            chk("tbl_illegal", 64'(out_illegal), 64'(vecs[i].exp_illegal));
            tick();
        end

        // Mid-stream reset with 3 entries
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h500 + 32'(i * 4), 32'h0000_0013, 1'b0, 1'b0);
            tick();
        end
        reset = 1'b1;
        drive(1'b1, 32'h50C, 32'h0000_0013, 1'b1, 1'b0);
        #1 chk("rst_in_ready", 64'(in_ready), 64'h0);
        tick();
        reset = 1'b0;
        drive(1'b0, 0, 0, 1'b0, 1'b0);
        #1;
        chk("rst_count", 64'(count), 64'h0);
        chk("rst_disp", 64'(dispatched), 64'h0);
        chk("rst_valid", 64'(out_valid), 64'h0);
        chk("rst_in_ready_after", 64'(in_ready), 64'h1);
        tick();

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            drive(($urandom_range(0, 9) < 7), $urandom, $urandom,
                  ($urandom_range(0, 9) < 6), ($urandom_range(0, 39) == 0));
            tick();
        end
        reset = 1'b0;
        drive(1'b0, 0, 0, 1'b0, 1'b0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
